irq_input_conditioner: RTL and testbench

Per-line conditioner for raw external interrupt pins, sitting directly upstream of the interrupt controller and driving its `ext_intr` input. Each line is synchronized, normalized to active-high, and glitch-filtered. It is then presented either as a filtered level or as a fixed-width pulse on each asserting edge. The block also keeps a sticky overrun flag for edge lines that re-assert while their pulse is still in progress.

---
 rtl/irq_input_conditioner.sv | 96 +++++++++
 tb/tb_irq_input_conditioner.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_input_conditioner.sv
// Per-line interrupt pin conditioner: synchronize, normalize polarity, glitch-filter,
// then present as a level or as a stretched pulse, with a sticky overrun flag per line.
module irq_input_conditioner #(
  parameter int unsigned           INTR_WIDTH    = 8,
  parameter int unsigned           SYNC_STAGES   = 2,
  parameter int unsigned           FILTER_CYCLES = 4,
  parameter int unsigned           PULSE_CYCLES  = 1,
  parameter logic [INTR_WIDTH-1:0] EDGE_MASK     = {INTR_WIDTH{1'b1}},
  parameter logic [INTR_WIDTH-1:0] POLARITY_MASK = {INTR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INTR_WIDTH-1:0] irq_in,
  input  logic [INTR_WIDTH-1:0] overrun_clear,
  output logic [INTR_WIDTH-1:0] ext_intr,
  output logic [INTR_WIDTH-1:0] irq_filtered,
  output logic [INTR_WIDTH-1:0] irq_overrun
);

  localparam logic [7:0] FILT_LAST  = 8'(FILTER_CYCLES - 1);
  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

  for (genvar i = 0; i < INTR_WIDTH; i++) begin : g_line
    // Reset loads the inactive pin level so no false edge follows reset release.
    localparam logic INACTIVE = ~POLARITY_MASK[i];
    localparam logic IS_EDGE  = EDGE_MASK[i];

    logic [SYNC_STAGES-1:0] sync_r;
    logic [7:0]             cnt_r;
    logic [7:0]             stretch_r;
    logic                   filt_r;
    logic                   filt_d_r;
    logic                   ext_r;
    logic                   ovr_r;
    logic                   sample_s;
    logic                   rise_s;
    logic                   ovr_set_s;

    assign sample_s  = sync_r[SYNC_STAGES-1] ^ INACTIVE;
    assign rise_s    = filt_r & ~filt_d_r;
    assign ovr_set_s = IS_EDGE & rise_s & ext_r & (stretch_r != 8'd0);

    // Synchronizer, debounce filter, output shaping and overrun flag for this line.
    always_ff @(posedge clk) begin
      if (reset) begin
        sync_r    <= {SYNC_STAGES{INACTIVE}};
        cnt_r     <= 8'd0;
        filt_r    <= 1'b0;
        filt_d_r  <= 1'b0;
        stretch_r <= 8'd0;
        ext_r     <= 1'b0;
        ovr_r     <= 1'b0;
      end else begin
        sync_r   <= {sync_r[SYNC_STAGES-2:0], irq_in[i]};
        filt_d_r <= filt_r;

        if (sample_s == filt_r) begin
          cnt_r <= 8'd0;
        end else if (cnt_r == FILT_LAST) begin
          filt_r <= sample_s;
          cnt_r  <= 8'd0;
        end else begin
          cnt_r <= cnt_r + 8'd1;
        end

        if (!IS_EDGE) begin
          ext_r     <= filt_r;
          stretch_r <= 8'd0;
        end else if (rise_s) begin
          ext_r     <= 1'b1;
          stretch_r <= PULSE_LAST;
        end else if (stretch_r != 8'd0) begin
          ext_r     <= 1'b1;
          stretch_r <= stretch_r - 8'd1;
        end else begin
          ext_r     <= 1'b0;
          stretch_r <= 8'd0;
        end

        // A new rise in the same cycle as a clear keeps the flag set.
        if (ovr_set_s) begin
          ovr_r <= 1'b1;
        end else if (overrun_clear[i]) begin
          ovr_r <= 1'b0;
        end else begin
          ovr_r <= ovr_r;
        end
      end
    end

    assign ext_intr[i]     = ext_r;
    assign irq_filtered[i] = filt_r;
    assign irq_overrun[i]  = ovr_r;
  end

endmodule

// File: tb/tb_irq_input_conditioner.sv
// Directed bench for irq_input_conditioner across four parameterizations,
// plus a random multi-line run against a per-line reference model.
module tb_irq_input_conditioner;

  localparam logic [7:0] MIX_EDGE = 8'hA5;
  localparam logic [7:0] MIX_POL  = 8'h3C;
  localparam int         MIX_FILT = 3;
  localparam int         MIX_PULS = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic [7:0] in_def = 8'h00, clr_def = 8'h00, ext_def, flt_def, ovr_def;
  logic [7:0] in_lvl = 8'h01, clr_lvl = 8'h00, ext_lvl, flt_lvl, ovr_lvl;
  logic [7:0] in_str = 8'h00, clr_str = 8'h00, ext_str, flt_str, ovr_str;
  logic [7:0] in_mix = 8'hC3, clr_mix = 8'h00, ext_mix, flt_mix, ovr_mix;

  always #5 clk = ~clk;

  irq_input_conditioner u_def (
    .clk(clk), .reset(reset), .irq_in(in_def), .overrun_clear(clr_def),
    .ext_intr(ext_def), .irq_filtered(flt_def), .irq_overrun(ovr_def)
  );

  irq_input_conditioner #(.EDGE_MASK(8'h00), .POLARITY_MASK(8'hFE)) u_lvl (
    .clk(clk), .reset(reset), .irq_in(in_lvl), .overrun_clear(clr_lvl),
    .ext_intr(ext_lvl), .irq_filtered(flt_lvl), .irq_overrun(ovr_lvl)
  );

  irq_input_conditioner #(.PULSE_CYCLES(8), .FILTER_CYCLES(1)) u_str (
    .clk(clk), .reset(reset), .irq_in(in_str), .overrun_clear(clr_str),
    .ext_intr(ext_str), .irq_filtered(flt_str), .irq_overrun(ovr_str)
  );

  irq_input_conditioner #(.SYNC_STAGES(3), .FILTER_CYCLES(MIX_FILT), .PULSE_CYCLES(MIX_PULS),
                          .EDGE_MASK(MIX_EDGE), .POLARITY_MASK(MIX_POL)) u_mix (
    .clk(clk), .reset(reset), .irq_in(in_mix), .overrun_clear(clr_mix),
    .ext_intr(ext_mix), .irq_filtered(flt_mix), .irq_overrun(ovr_mix)
  );

  // Reference model state for u_mix.
  logic [2:0] m_sync [8];
  logic [7:0] m_cnt  [8];
  logic [7:0] m_str  [8];
  logic [7:0] m_filt, m_filtd, m_ext, m_ovr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic model_step();
    logic s, rise, old_f;
    for (int i = 0; i < 8; i++) begin
      s     = m_sync[i][2] ^ ~MIX_POL[i];
      old_f = m_filt[i];
      rise  = m_filt[i] & ~m_filtd[i];
      if (MIX_EDGE[i] && rise && m_ext[i] && (m_str[i] != 8'd0)) m_ovr[i] = 1'b1;
      else if (clr_mix[i]) m_ovr[i] = 1'b0;
      if (!MIX_EDGE[i]) begin
        m_ext[i] = old_f;
      end else if (rise) begin
        m_ext[i] = 1'b1;
        m_str[i] = 8'(MIX_PULS - 1);
      end else if (m_str[i] != 8'd0) begin
        m_ext[i] = 1'b1;
        m_str[i] = m_str[i] - 8'd1;
      end else begin
        m_ext[i] = 1'b0;
      end
      if (s == old_f) m_cnt[i] = 8'd0;
      else if (m_cnt[i] == 8'(MIX_FILT - 1)) begin
        m_filt[i] = s;
        m_cnt[i]  = 8'd0;
      end else m_cnt[i] = m_cnt[i] + 8'd1;
      m_filtd[i] = old_f;
      m_sync[i]  = {m_sync[i][1:0], in_mix[i]};
    end
  endtask

  initial begin
    int hold [8];

    // Test 1: held assertion on a default edge line.
    tick();
    do_reset();
    check("rst_ext", {24'd0, ext_def}, 32'h0);
    check("rst_flt", {24'd0, flt_def}, 32'h0);
    check("rst_ovr", {24'd0, ovr_def}, 32'h0);
    in_def[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_flt", {24'd0, flt_def}, (k >= 5) ? 32'h1 : 32'h0);
      check("t1_ext", {24'd0, ext_def}, (k == 6) ? 32'h1 : 32'h0);
      check("t1_ovr", {24'd0, ovr_def}, 32'h0);
    end
    in_def = 8'h00;

    // Test 2: 3-cycle glitch is rejected, 4-cycle pulse passes.
    do_reset();
    in_def[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k == 2) in_def[1] = 1'b0;
      check("t2_short_ext", {24'd0, ext_def}, 32'h0);
      check("t2_short_flt", {24'd0, flt_def}, 32'h0);
    end
    do_reset();
    in_def[1] = 1'b1;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (k == 3) in_def[1] = 1'b0;
      check("t2_min_ext", {24'd0, ext_def}, (k == 6) ? 32'h2 : 32'h0);
      check("t2_min_flt", {24'd0, flt_def}, (k >= 5 && k <= 8) ? 32'h2 : 32'h0);
    end

    // Test 3: active-low level line, 10-cycle assertion.
    in_lvl = 8'h01;
    do_reset();
    in_lvl[0] = 1'b0;
    for (int k = 0; k < 19; k++) begin
      tick();
      if (k == 9) in_lvl[0] = 1'b1;
      check("t3_ext", {24'd0, ext_lvl}, (k >= 6 && k <= 15) ? 32'h1 : 32'h0);
      check("t3_flt", {24'd0, flt_lvl}, (k >= 5 && k <= 14) ? 32'h1 : 32'h0);
      check("t3_ovr", {24'd0, ovr_lvl}, 32'h0);
    end

    // Test 4: re-rise during a stretched pulse, set-vs-clear priority, clear alone.
    do_reset();
    in_str[2] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      in_str[2]  = !((k + 1) == 1 || (k + 1) == 3);
      clr_str[2] = ((k + 1) == 7) || ((k + 1) == 17);
      check("t4_ext", {24'd0, ext_str}, (k >= 3 && k <= 14) ? 32'h4 : 32'h0);
      check("t4_ovr", {24'd0, ovr_str}, (k >= 5 && k < 17) ? 32'h4 : 32'h0);
      check("t4_flt", {24'd0, flt_str}, (k >= 2 && k != 3 && k != 5) ? 32'h4 : 32'h0);
    end
    clr_str = 8'h00;

    // Test 5: one-cycle reset in the middle of a pulse, pin held high.
    do_reset();
    in_str[2] = 1'b1;
    for (int k = 0; k < 19; k++) begin
      tick();
      check("t5_ext", {24'd0, ext_str},
            ((k >= 3 && k <= 4) || (k >= 9 && k <= 16)) ? 32'h4 : 32'h0);
      check("t5_flt", {24'd0, flt_str}, ((k >= 2 && k <= 4) || k >= 8) ? 32'h4 : 32'h0);
      if (k == 5) check("t5_ovr", {24'd0, ovr_str}, 32'h0);
      if (k == 4) reset = 1'b1;
      else reset = 1'b0;
    end
    in_str = 8'h00;

    // Test 6: all lines toggling with independent widths vs. reference model.
    in_mix = ~MIX_POL;
    do_reset();
    check("t6_rst", {8'd0, ext_mix, flt_mix, ovr_mix}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      m_sync[i] = {3{~MIX_POL[i]}};
      m_cnt[i]  = 8'd0;
      m_str[i]  = 8'd0;
      hold[i]   = int'($urandom_range(1, 7));
    end
    m_filt = 8'h00; m_filtd = 8'h00; m_ext = 8'h00; m_ovr = 8'h00;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          in_mix[i] = ~in_mix[i];
          hold[i]   = int'($urandom_range(1, 7));
        end
      end
      clr_mix = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      model_step();
      tick();
      check("t6_ext", {24'd0, ext_mix}, {24'd0, m_ext});
      check("t6_flt", {24'd0, flt_mix}, {24'd0, m_filt});
      check("t6_ovr", {24'd0, ovr_mix}, {24'd0, m_ovr});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
